legv8_instr_encoder: RTL and testbench
======================================

// Module: legv8_instr_encoder
// PURPOSE
//  Program loader for the single-cycle LEGv8 core. It is the encoding side of the opcode decoder.
//  It accepts symbolic instructions (op + register/immediate fields) over a valid/ready stream.
//  It packs each one into a 32-bit LEGv8 word and writes the words to instruction memory at
//  consecutive addresses through a req/ack port. The bench and boot logic use it to load programs.
// PARAMETERS
//  ADDR_W     64  width of mem_addr / base_addr
//  ADDR_STEP  4   byte increment of mem_addr per word written
//  CNT_W      16  width of count / written
// PORTS
//  clk        in   1       single clock, rising edge
//  reset_n    in   1       asynchronous, active-low reset
//  start      in   1       1-cycle pulse: load base_addr/count, begin a program load (ignored if busy)
//  abort      in   1       sync: drop any pending write, go IDLE, no done pulse
//  base_addr  in   ADDR_W  first write address
//  count      in   CNT_W   number of legal instructions to write
//  in_valid   in   1       instruction fields valid
//  in_ready   out  1       encoder can accept an instruction
//  op         in   4       0 ADDI,1 ADDS,2 B,3 BLT,4 CBZ,5 LDUR,6 LSL,7 LSR,8 MUL,9 STUR,10 SUBS; 11-15 illegal
//  rd         in   5       Rd / Rt (STUR data, CBZ test register)
//  rn         in   5       Rn
//  rm         in   5       Rm
//  imm        in   26      immediate / shamt / branch offset (low bits used)
//  mem_we     out  1       write request, held until acked
//  mem_ack    in   1       memory accepted the write this cycle
//  mem_addr   out  ADDR_W  write address
//  mem_wdata  out  32      encoded instruction
//  busy       out  1       load in progress (ARMED or WRITE)
//  done       out  1       1-cycle pulse after the last word is acked
//  err        out  1       sticky: an illegal op was consumed; cleared by start
//  written    out  CNT_W   words acked since start
// BEHAVIOUR
//  Reset (async): state IDLE. in_ready, mem_we, busy, done and err are 0. mem_addr, mem_wdata and written are 0.
//  FSM states: IDLE, ARMED, WRITE, DONE.
//   IDLE -> start: latch base_addr into mem_addr and count into remaining; clear written and err.
//    If count==0 -> DONE, else -> ARMED.
//   ARMED: in_ready=1. On in_valid&&in_ready:
//    Legal op: register the encoded word in mem_wdata, assert mem_we next cycle, go to WRITE.
//    Illegal op: consume and discard it, set err, stay in ARMED. Address and remaining are unchanged.
//   WRITE: in_ready=0. mem_we, mem_addr and mem_wdata are held stable until mem_ack.
//    Any cycle with mem_we&&mem_ack completes the write, including the first such cycle.
//    On completion: mem_we=0, mem_addr+=ADDR_STEP (wraps mod 2^ADDR_W), written+=1, remaining-=1.
//    Then go to DONE if remaining==0, else to ARMED.
//   DONE: done=1 for exactly 1 cycle, then IDLE. mem_addr keeps the next-free address.
//  Latency: handshake to mem_we is 1 cycle. The fastest rate is 1 word per 2 cycles with mem_ack tied high.
//  mem_ack is ignored outside WRITE. start is ignored unless in IDLE.
//  abort has priority over every transition: go IDLE, mem_we=0, no done. written and err hold.
//  Encoding (imm truncated to the listed low bits):
//   R  ADDS 10101011000, SUBS 11101011000: [31:21]op [20:16]rm [15:10]0 [9:5]rn [4:0]rd
//   R  MUL 10011011000: shamt field = 6'h1F
//   R  LSL 11010011011, LSR 11010011010: rm=0, shamt=imm[5:0]
//   I  ADDI [31:22]1001000100 [21:10]imm[11:0] [9:5]rn [4:0]rd
//   D  LDUR 11111000010, STUR 11111000000: [20:12]imm[8:0] [11:10]00 [9:5]rn [4:0]rd
//   B  [31:26]000101 [25:0]imm[25:0]
//   CB CBZ [31:24]10110100 [23:5]imm[18:0] [4:0]rd
//   CB BLT [31:24]01010100 [23:5]imm[18:0] [4:0]5'b01011 (cond LT); rd ignored
// TESTING
//  Encoding, mem_ack=1, base 0x100, count 1, ADDI rd1 rn2 imm5 -> 0x91001441 @0x100; done pulse; written=1.
//  ADDS 0/1/2 -> 0xAB020020; MUL 1/2/3 -> 0x9B037C41; LDUR rd4 rn5 imm8 -> 0xF84080A4.
//  Branches: B imm=26'h3FFFFFF -> 0x17FFFFFF; CBZ rd3 imm2 -> 0xB4000043; BLT imm3 rd7 -> 0x5400006B.
//  Stall: hold mem_ack=0 for 5 cycles -> mem_we, mem_addr and mem_wdata are stable and in_ready=0.
//   Ack -> addr+4, in_ready=1 the next cycle.
//  Illegal op: count 2, ops 3, 13, 6 -> err=1; 2 words written at base, base+4; done after the 2nd word.
//  Boundaries: start with count=0 -> done 1 cycle later, no mem_we. base=2^64-4, count 2 -> 2nd address 0.
//  Abort/reset: abort or reset_n=0 while in WRITE -> mem_we drops, IDLE, no done.
//   After reset all outputs are 0; start while busy has no effect.

Source files
------------

// File: rtl/legv8_instr_encoder.sv
// Program loader: packs symbolic LEGv8 instructions into 32-bit words and writes them
// to instruction memory at consecutive addresses over a req/ack port.
module legv8_instr_encoder #(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned ADDR_STEP = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [4:0]        rd,
    input  logic [4:0]        rn,
    input  logic [4:0]        rm,
    input  logic [25:0]       imm,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  written
);

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  written_q, written_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;

    logic              legal_c;
    logic [WORD_W-1:0] enc_word_c;
    logic              accept_c;
    logic              write_done_c;

    // Returns {legal, word}; unknown opcodes come back with legal = 0.
    function automatic logic [WORD_W:0] encode(input logic [3:0] o, input logic [4:0] d,
                                               input logic [4:0] n, input logic [4:0] m,
                                               input logic [25:0] im);
        logic [WORD_W:0] r;
        r = '0;
        case (o)
            4'd0:    r = {1'b1, 10'b1001000100, im[11:0], n, d};
            4'd1:    r = {1'b1, 11'b10101011000, m, 6'h00, n, d};
            4'd2:    r = {1'b1, 6'b000101, im[25:0]};
            4'd3:    r = {1'b1, 8'b01010100, im[18:0], 5'b01011};
            4'd4:    r = {1'b1, 8'b10110100, im[18:0], d};
            4'd5:    r = {1'b1, 11'b11111000010, im[8:0], 2'b00, n, d};
            4'd6:    r = {1'b1, 11'b11010011011, 5'b00000, im[5:0], n, d};
            4'd7:    r = {1'b1, 11'b11010011010, 5'b00000, im[5:0], n, d};
            4'd8:    r = {1'b1, 11'b10011011000, m, 6'h1F, n, d};
            4'd9:    r = {1'b1, 11'b11111000000, im[8:0], 2'b00, n, d};
            4'd10:   r = {1'b1, 11'b11101011000, m, 6'h00, n, d};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign {legal_c, enc_word_c} = encode(op, rd, rn, rm, imm);
    assign accept_c     = (state_q == ST_ARMED) && in_valid && in_ready_q;
    assign write_done_c = (state_q == ST_WRITE) && mem_we_q && mem_ack;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start) state_d = (count == '0) ? ST_DONE : ST_ARMED;
                ST_ARMED: if (accept_c && legal_c) state_d = ST_WRITE;
                ST_WRITE: if (write_done_c)
                              state_d = (remaining_q == CNT_W'(1)) ? ST_DONE : ST_ARMED;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Output and datapath next values; flags are decoded from the next state so they register in step
    always_comb begin
        in_ready_d  = (state_d == ST_ARMED);
        mem_we_d    = (state_d == ST_WRITE);
        busy_d      = (state_d == ST_ARMED) || (state_d == ST_WRITE);
        done_d      = (state_d == ST_DONE);
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        written_d   = written_q;
        remaining_d = remaining_q;
        if (!abort) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mem_addr_d  = base_addr;
                        remaining_d = count;
                        written_d   = '0;
                        err_d       = 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (accept_c) begin
                        if (legal_c) mem_wdata_d = enc_word_c;
                        else         err_d       = 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (write_done_c) begin
                        mem_addr_d  = mem_addr_q + ADDR_W'(ADDR_STEP);
                        written_d   = written_q + CNT_W'(1);
                        remaining_d = remaining_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            written_q   <= '0;
            remaining_q <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            written_q   <= written_d;
            remaining_q <= remaining_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign written   = written_q;

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Bench for legv8_instr_encoder: directed encodings, stalls, illegal ops, boundaries, abort/reset,
// and randomized program loads against an arithmetic encoding model.
module tb_legv8_instr_encoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, abort, in_valid, mem_ack;
    logic [63:0] base_addr;
    logic [15:0] count;
    logic [3:0]  op;
    logic [4:0]  rd, rn, rm;
    logic [25:0] imm;
    logic        in_ready, mem_we, busy, done, err;
    logic [63:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [15:0] written;

    int n_cmp = 0;
    int n_bad = 0;

    legv8_instr_encoder dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .base_addr(base_addr), .count(count), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .rn(rn), .rm(rm), .imm(imm),
        .mem_we(mem_we), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .written(written)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference encoder: field values scaled into place with plain arithmetic
    function automatic logic [31:0] model_enc(input int o, input int d, input int n, input int m,
                                              input longint unsigned im, output bit legal);
        longint unsigned w;
        legal = 1'b1;
        case (o)
            0:  w = (64'h244 << 22) + (im % 4096) * 1024 + n * 32 + d;
            1:  w = (64'h558 << 21) + m * 65536 + n * 32 + d;
            2:  w = (64'h5 << 26) + (im % 67108864);
            3:  w = (64'h54 << 24) + (im % 524288) * 32 + 11;
            4:  w = (64'hB4 << 24) + (im % 524288) * 32 + d;
            5:  w = (64'h7C2 << 21) + (im % 512) * 4096 + n * 32 + d;
            6:  w = (64'h69B << 21) + (im % 64) * 1024 + n * 32 + d;
            7:  w = (64'h69A << 21) + (im % 64) * 1024 + n * 32 + d;
            8:  w = (64'h4D8 << 21) + m * 65536 + 31 * 1024 + n * 32 + d;
            9:  w = (64'h7C0 << 21) + (im % 512) * 4096 + n * 32 + d;
            10: w = (64'h758 << 21) + m * 65536 + n * 32 + d;
            default: begin w = 0; legal = 1'b0; end
        endcase
        return w[31:0];
    endfunction

    task automatic start_load(input logic [63:0] b, input logic [15:0] c);
        base_addr = b;
        count     = c;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // One instruction transaction from ARMED; stall = cycles of mem_ack low while the write is pending
    task automatic send_instr(input string tag, input int o, input int d, input int n, input int m,
                              input logic [25:0] im, input int stall, input logic [63:0] exp_addr);
        bit          legal;
        logic [31:0] exp_w;
        exp_w    = model_enc(o, d, n, m, im, legal);
        op       = 4'(o);
        rd       = 5'(d);
        rn       = 5'(n);
        rm       = 5'(m);
        imm      = im;
        in_valid = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready_before: in_ready=%b expected 1", tag, in_ready);
        end
        tick();
        in_valid = 1'b0;
        if (!legal) begin
            n_cmp++;
            if ({mem_we, err, in_ready, mem_addr} !== {3'b011, exp_addr}) begin
                n_bad++;
                $display("FAIL %s illegal: we/err/rdy=%b%b%b addr=%h expected 011 addr=%h",
                         tag, mem_we, err, in_ready, mem_addr, exp_addr);
            end
            return;
        end
        n_cmp++;
        if ({mem_we, in_ready, busy, mem_wdata, mem_addr} !== {3'b101, exp_w, exp_addr}) begin
            n_bad++;
            $display("FAIL %s write: we/rdy/busy=%b%b%b wdata=%h addr=%h expected 101 wdata=%h addr=%h",
                     tag, mem_we, in_ready, busy, mem_wdata, mem_addr, exp_w, exp_addr);
        end
        for (int i = 0; i < stall; i++) begin
            tick();
            n_cmp++;
            if ({mem_we, in_ready, mem_wdata, mem_addr} !== {2'b10, exp_w, exp_addr}) begin
                n_bad++;
                $display("FAIL %s stall%0d: we/rdy=%b%b wdata=%h addr=%h expected 10 wdata=%h addr=%h",
                         tag, i, mem_we, in_ready, mem_wdata, mem_addr, exp_w, exp_addr);
            end
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if ({mem_we, mem_addr} !== {1'b0, exp_addr + 64'd4}) begin
            n_bad++;
            $display("FAIL %s ack: we=%b addr=%h expected 0 addr=%h", tag, mem_we, mem_addr,
                     exp_addr + 64'd4);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 0; abort = 0; in_valid = 0; mem_ack = 0;
        base_addr = 0; count = 0; op = 0; rd = 0; rn = 0; rm = 0; imm = 0;
        repeat (3) tick();
        n_cmp++;
        if ({in_ready, mem_we, busy, done, err, mem_addr, mem_wdata, written} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: rdy/we/busy/done/err=%b%b%b%b%b addr=%h wdata=%h written=%0d expected all 0",
                     in_ready, mem_we, busy, done, err, mem_addr, mem_wdata, written);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_encoding();
        int          ops[7]  = '{0, 1, 8, 5, 2, 4, 3};
        int          rds[7]  = '{1, 0, 1, 4, 0, 3, 7};
        int          rns[7]  = '{2, 1, 2, 5, 0, 0, 0};
        int          rms[7]  = '{0, 2, 3, 0, 0, 0, 0};
        logic [25:0] imms[7] = '{26'd5, 26'd0, 26'd0, 26'd8, 26'h3FFFFFF, 26'd2, 26'd3};
        logic [31:0] gold[7] = '{32'h91001441, 32'hAB020020, 32'h9B037C41, 32'hF84080A4,
                                 32'h17FFFFFF, 32'hB4000043, 32'h5400006B};
        for (int i = 0; i < 7; i++) begin
            start_load(64'h100, 16'd1);
            op = 4'(ops[i]); rd = 5'(rds[i]); rn = 5'(rns[i]); rm = 5'(rms[i]); imm = imms[i];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            n_cmp++;
            if ({mem_we, mem_wdata, mem_addr} !== {1'b1, gold[i], 64'h100}) begin
                n_bad++;
                $display("FAIL enc_%0d: we=%b wdata=%h addr=%h expected 1 wdata=%h addr=100",
                         i, mem_we, mem_wdata, mem_addr, gold[i]);
            end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            n_cmp++;
            if ({done, busy, mem_we, written} !== {3'b100, 16'd1}) begin
                n_bad++;
                $display("FAIL enc_done_%0d: done/busy/we=%b%b%b written=%0d expected 100 written=1",
                         i, done, busy, mem_we, written);
            end
            tick();
            n_cmp++;
            if ({done, busy} !== 2'b00) begin
                n_bad++;
                $display("FAIL enc_idle_%0d: done/busy=%b%b expected 00", i, done, busy);
            end
        end
    endtask

    task automatic test_stall();
        start_load(64'h200, 16'd2);
        send_instr("stall1", 1, 3, 4, 5, 26'd0, 5, 64'h200);
        n_cmp++;
        if ({in_ready, busy, done} !== 3'b110) begin
            n_bad++;
            $display("FAIL stall_rearm: rdy/busy/done=%b%b%b expected 110", in_ready, busy, done);
        end
        send_instr("stall2", 10, 6, 7, 8, 26'd0, 0, 64'h204);
        n_cmp++;
        if ({done, written, mem_addr} !== {1'b1, 16'd2, 64'h208}) begin
            n_bad++;
            $display("FAIL stall_done: done=%b written=%0d addr=%h expected 1 2 208", done, written, mem_addr);
        end
        tick();
    endtask

    task automatic test_illegal();
        start_load(64'h300, 16'd2);
        send_instr("ill_blt", 3, 1, 0, 0, 26'd9, 1, 64'h300);
        send_instr("ill_13", 13, 2, 2, 2, 26'd1, 0, 64'h304);
        send_instr("ill_lsl", 6, 4, 5, 0, 26'd3, 0, 64'h304);
        n_cmp++;
        if ({done, err, written} !== {2'b11, 16'd2}) begin
            n_bad++;
            $display("FAIL illegal_done: done=%b err=%b written=%0d expected 1 1 2", done, err, written);
        end
        tick();
        start_load(64'h400, 16'd0);
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: err=%b expected 0", err);
        end
        tick();
    endtask

    task automatic test_count_zero();
        start_load(64'h500, 16'd0);
        n_cmp++;
        if ({done, busy, mem_we, in_ready, mem_addr, written} !== {4'b1000, 64'h500, 16'd0}) begin
            n_bad++;
            $display("FAIL cnt0: done/busy/we/rdy=%b%b%b%b addr=%h written=%0d expected 1000 500 0",
                     done, busy, mem_we, in_ready, mem_addr, written);
        end
        tick();
        n_cmp++;
        if ({done, mem_we} !== 2'b00) begin
            n_bad++;
            $display("FAIL cnt0_after: done/we=%b%b expected 00", done, mem_we);
        end
    endtask

    task automatic test_wrap();
        start_load(64'hFFFF_FFFF_FFFF_FFFC, 16'd2);
        send_instr("wrap1", 7, 1, 1, 0, 26'd63, 0, 64'hFFFF_FFFF_FFFF_FFFC);
        send_instr("wrap2", 9, 2, 3, 0, 26'h1FF, 2, 64'h0);
        n_cmp++;
        if ({done, mem_addr} !== {1'b1, 64'h4}) begin
            n_bad++;
            $display("FAIL wrap_end: done=%b addr=%h expected 1 4", done, mem_addr);
        end
        tick();
    endtask

    task automatic test_start_busy();
        start_load(64'h600, 16'd2);
        start_load(64'h900, 16'd0);
        n_cmp++;
        if ({busy, in_ready, done, mem_addr} !== {3'b110, 64'h600}) begin
            n_bad++;
            $display("FAIL start_busy: busy/rdy/done=%b%b%b addr=%h expected 110 600",
                     busy, in_ready, done, mem_addr);
        end
        send_instr("sb1", 0, 1, 1, 0, 26'd1, 0, 64'h600);
        send_instr("sb2", 0, 2, 2, 0, 26'd2, 0, 64'h604);
        tick();
    endtask

    task automatic test_abort();
        start_load(64'h700, 16'd3);
        op = 4'd1; rd = 5'd1; rn = 5'd2; rm = 5'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if ({mem_we, busy, in_ready, done, written} !== {4'b0000, 16'd0}) begin
            n_bad++;
            $display("FAIL abort: we/busy/rdy/done=%b%b%b%b written=%0d expected 0000 0",
                     mem_we, busy, in_ready, done, written);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if ({done, mem_we, written} !== {2'b00, 16'd0}) begin
            n_bad++;
            $display("FAIL abort_after: done/we=%b%b written=%0d expected 00 0", done, mem_we, written);
        end
        // Reset asynchronously in the middle of a pending write
        start_load(64'h800, 16'd2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, mem_we, busy, done, err, mem_addr, mem_wdata, written} !== '0) begin
            n_bad++;
            $display("FAIL reset_in_write: rdy/we/busy/done/err=%b%b%b%b%b addr=%h wdata=%h expected all 0",
                     in_ready, mem_we, busy, done, err, mem_addr, mem_wdata);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            logic [63:0] base;
            int          cnt, legal_sent;
            bit          exp_err, lg;
            logic [31:0] unused_w;
            base = {$urandom(), $urandom()};
            cnt  = $urandom_range(1, 5);
            legal_sent = 0;
            exp_err = 1'b0;
            start_load(base, 16'(cnt));
            while (legal_sent < cnt) begin
                int o;
                o = $urandom_range(0, 15);
                unused_w = model_enc(o, 0, 0, 0, 0, lg);
                send_instr($sformatf("rnd%0d_%0d", it, legal_sent), o, $urandom_range(0, 31),
                           $urandom_range(0, 31), $urandom_range(0, 31), 26'($urandom()),
                           $urandom_range(0, 3), base + 64'(4 * legal_sent));
                if (lg) legal_sent++;
                else    exp_err = 1'b1;
            end
            n_cmp++;
            if ({done, err, written, mem_addr} !== {1'b1, exp_err, 16'(cnt), base + 64'(4 * cnt)}) begin
                n_bad++;
                $display("FAIL rnd_end%0d: done=%b err=%b written=%0d addr=%h expected 1 %b %0d %h",
                         it, done, err, written, mem_addr, exp_err, cnt, base + 64'(4 * cnt));
            end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time=%0t expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_encoding();
        test_stall();
        test_illegal();
        test_count_zero();
        test_wrap();
        test_start_busy();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
